// File: rtl/stage_writeback_pkg.sv
// Shared writeback-stage types: write-back source select, load kinds and the pipeline-register payload.
package signals;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } load_type_t;

  // Select fields stay raw vectors so reserved encodings survive the register and decode to 0.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pcadd8;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        wb_sel;
    logic [2:0]        load_type;
    logic [ADDR_W-1:0] dest_reg;
    logic              write_reg;
  } wb_stage_t;

endpackage

// File: rtl/stage_writeback_load_extract.sv
// Little-endian load alignment: picks the byte/half at the address offset and sign/zero extends it.
module load_extract
  import signals::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       offset,
  input  logic [2:0]       load_type,
  output logic [WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // offset[0] is ignored for halves; misaligned halves never reach this stage.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = '0;
    case (load_type)
      LD_W:  data = rdata;
      LD_B:  data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      LD_BU: data = {{(WIDTH-8){1'b0}}, byte_sel};
      LD_H:  data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      LD_HU: data = {{(WIDTH-16){1'b0}}, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/stage_writeback.sv
// Final pipeline stage: register-file write port back to decode, retire PC and retired-instruction count.
// Define STAGE_WRITEBACK_BYPASS_EN to add same-cycle write-before-read forwarding ports for decode.
module stage_writeback
  import signals::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_ADDR  = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 nullify,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     pc_in,
  input  logic [WIDTH-1:0]     pcadd8_in,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic [1:0]           wb_sel,
  input  logic [2:0]           load_type,
  input  logic [REG_ADDR-1:0]  dest_reg_in,
  input  logic                 write_reg_in,
`ifdef STAGE_WRITEBACK_BYPASS_EN
  input  logic [REG_ADDR-1:0]  rs_addr,
  input  logic [REG_ADDR-1:0]  rt_addr,
  input  logic [WIDTH-1:0]     rs_rf,
  input  logic [WIDTH-1:0]     rt_rf,
  output logic [WIDTH-1:0]     rs_fwd,
  output logic [WIDTH-1:0]     rt_fwd,
`endif
  output logic [REG_ADDR-1:0]  dest_reg,
  output logic [WIDTH-1:0]     dest_reg_data,
  output logic                 write_reg,
  output logic                 retire_valid,
  output logic [WIDTH-1:0]     retire_pc,
  output logic [CNT_WIDTH-1:0] retired_count
);

  wb_stage_t           stage_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [WIDTH-1:0]     load_data;
  logic                 retire;

  // nullify beats stall so a squashed instruction can never retire from a held register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_reg <= '0;
    end else if (nullify) begin
      stage_reg <= '0;
    end else if (!stall) begin
      stage_reg.valid      <= valid_in;
      stage_reg.pc         <= pc_in;
      stage_reg.pcadd8     <= pcadd8_in;
      stage_reg.alu_result <= alu_result;
      stage_reg.mem_rdata  <= mem_rdata;
      stage_reg.wb_sel     <= wb_sel;
      stage_reg.load_type  <= load_type;
      stage_reg.dest_reg   <= dest_reg_in;
      stage_reg.write_reg  <= write_reg_in;
    end
  end

  load_extract #(
    .WIDTH(WIDTH)
  ) u_load_extract (
    .rdata     (stage_reg.mem_rdata),
    .offset    (stage_reg.alu_result[1:0]),
    .load_type (stage_reg.load_type),
    .data      (load_data)
  );

  always_comb begin
    dest_reg_data = '0;
    case (stage_reg.wb_sel)
      WB_ALU:  dest_reg_data = stage_reg.alu_result;
      WB_MEM:  dest_reg_data = load_data;
      WB_LINK: dest_reg_data = stage_reg.pcadd8;
      default: dest_reg_data = '0;
    endcase
  end

  // A held instruction only acts on the cycle it leaves the stage, so the write and count happen once.
  assign retire       = stage_reg.valid & ~stall;
  assign write_reg    = retire & stage_reg.write_reg & (stage_reg.dest_reg != '0);
  assign dest_reg     = stage_reg.dest_reg;
  assign retire_valid = retire;
  assign retire_pc    = retire ? stage_reg.pc : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (retire) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign retired_count = count_reg;

`ifdef STAGE_WRITEBACK_BYPASS_EN
  assign rs_fwd = (write_reg && (rs_addr == dest_reg)) ? dest_reg_data : rs_rf;
  assign rt_fwd = (write_reg && (rt_addr == dest_reg)) ? dest_reg_data : rt_rf;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// Scoreboard bench for stage_writeback: stimulus queues expected retirements, a negedge monitor checks them.
module tb_stage_writeback;
  import signals::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        nullify;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [31:0] pcadd8_in;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [1:0]  wb_sel;
  logic [2:0]  load_type;
  logic [4:0]  dest_reg_in;
  logic        write_reg_in;
  logic [4:0]  dest_reg;
  logic [31:0] dest_reg_data;
  logic        write_reg;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retired_count;
`ifdef STAGE_WRITEBACK_BYPASS_EN
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_rf;
  logic [31:0] rt_rf;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;
`endif

  always #5 clk = ~clk;

  stage_writeback dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .nullify       (nullify),
    .valid_in      (valid_in),
    .pc_in         (pc_in),
    .pcadd8_in     (pcadd8_in),
    .alu_result    (alu_result),
    .mem_rdata     (mem_rdata),
    .wb_sel        (wb_sel),
    .load_type     (load_type),
    .dest_reg_in   (dest_reg_in),
    .write_reg_in  (write_reg_in),
`ifdef STAGE_WRITEBACK_BYPASS_EN
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_rf         (rs_rf),
    .rt_rf         (rt_rf),
    .rs_fwd        (rs_fwd),
    .rt_fwd        (rt_fwd),
`endif
    .dest_reg      (dest_reg),
    .dest_reg_data (dest_reg_data),
    .write_reg     (write_reg),
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .retired_count (retired_count)
  );

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    logic        we;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_write_reg"}, {31'd0, write_reg}, 32'd0);
    check({tag, "_dest_reg"}, {27'd0, dest_reg}, 32'd0);
    check({tag, "_dest_reg_data"}, dest_reg_data, 32'd0);
    check({tag, "_retire_valid"}, {31'd0, retire_valid}, 32'd0);
    check({tag, "_retire_pc"}, retire_pc, 32'd0);
    check({tag, "_retired_count"}, retired_count, 32'd0);
  endtask

  task automatic drive(input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc, input logic [4:0] dst,
                       input logic wr);
    valid_in     = 1'b1;
    pc_in        = pc;
    pcadd8_in    = pc + 32'd8;
    alu_result   = alu;
    mem_rdata    = rdata;
    wb_sel       = sel;
    load_type    = lt;
    dest_reg_in  = dst;
    write_reg_in = wr;
  endtask

  // Issue one instruction, queue its expected retirement, return 1 time unit after the capturing edge.
  task automatic send(input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] alu,
                      input logic [31:0] rdata, input logic [31:0] pc, input logic [4:0] dst,
                      input logic wr, input logic [31:0] exp_data);
    exp_t e;
    drive(sel, lt, alu, rdata, pc, dst, wr);
    e.dest = dst;
    e.data = exp_data;
    e.we   = wr && (dst != 5'd0);
    e.pc   = pc;
    e.cnt  = exp_count;
    sb.push_back(e);
    exp_count = exp_count + 32'd1;
    @(posedge clk);
    #1;
    valid_in     = 1'b0;
    write_reg_in = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && retire_valid) begin
        $display("retire pc=0x%08h dest=%0d data=0x%08h we=%0b count=%0d",
                 retire_pc, dest_reg, dest_reg_data, write_reg, retired_count);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got pc 0x%08h expected no retirement", retire_pc);
        end else begin
          e = sb.pop_front();
          check("retire_pc", retire_pc, e.pc);
          check("dest_reg", {27'd0, dest_reg}, {27'd0, e.dest});
          check("dest_reg_data", dest_reg_data, e.data);
          check("write_reg", {31'd0, write_reg}, {31'd0, e.we});
          check("retired_count", retired_count, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int wait_cycles;
    reset = 1'b0; stall = 1'b0; nullify = 1'b0; valid_in = 1'b0;
    pc_in = '0; pcadd8_in = '0; alu_result = '0; mem_rdata = '0;
    wb_sel = '0; load_type = '0; dest_reg_in = '0; write_reg_in = 1'b0;
`ifdef STAGE_WRITEBACK_BYPASS_EN
    rs_addr = '0; rt_addr = '0; rs_rf = '0; rt_rf = '0;
`endif
    #12;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // ALU write; count shows the retirement one cycle later
    send(WB_ALU, LD_W, 32'h0000_1234, 32'h0, 32'h0000_0100, 5'd5, 1'b1, 32'h0000_1234);
    @(posedge clk); #1;
    check("count_after_first", retired_count, 32'd1);

    // Loads from 0x80FF7F01
    send(WB_MEM, LD_B,  32'h0000_1003, 32'h80FF_7F01, 32'h0000_0104, 5'd1, 1'b1, 32'hFFFF_FF80);
    send(WB_MEM, LD_BU, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_0108, 5'd2, 1'b1, 32'h0000_0080);
    send(WB_MEM, LD_H,  32'h0000_1002, 32'h80FF_7F01, 32'h0000_010C, 5'd3, 1'b1, 32'hFFFF_80FF);
    send(WB_MEM, LD_HU, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_0110, 5'd4, 1'b1, 32'h0000_7F01);
    send(WB_MEM, LD_B,  32'h0000_1001, 32'h80FF_7F01, 32'h0000_0114, 5'd6, 1'b1, 32'h0000_007F);
    send(WB_MEM, LD_W,  32'h0000_1000, 32'h80FF_7F01, 32'h0000_0118, 5'd8, 1'b1, 32'h80FF_7F01);
    send(WB_MEM, LD_HU, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_011C, 5'd10, 1'b1, 32'h0000_80FF);

    // Link, then link to $0 (retires and counts without writing), then reserved select
    send(WB_LINK, LD_W, 32'h0, 32'h0, 32'h0000_0400, 5'd31, 1'b1, 32'h0000_0408);
    send(WB_LINK, LD_W, 32'h0, 32'h0, 32'h0000_0400, 5'd0,  1'b1, 32'h0000_0408);
    send(2'd3,   LD_W, 32'hDEAD_BEEF, 32'h0, 32'h0000_0410, 5'd11, 1'b1, 32'h0);
    send(WB_ALU, LD_W, 32'h0000_0077, 32'h0, 32'h0000_0414, 5'd12, 1'b0, 32'h0000_0077);

    // Stall for 3 cycles: held, no write, count frozen; one retirement on release
    send(WB_ALU, LD_W, 32'h0000_0055, 32'h0, 32'h0000_0500, 5'd9, 1'b1, 32'h0000_0055);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_retire_valid", {31'd0, retire_valid}, 32'd0);
      check("stall_write_reg", {31'd0, write_reg}, 32'd0);
      check("stall_dest_reg", {27'd0, dest_reg}, 32'd9);
      check("stall_dest_reg_data", dest_reg_data, 32'h0000_0055);
      check("stall_count", retired_count, exp_count - 32'd1);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    check("count_after_stall", retired_count, exp_count);

    // nullify with stall turns the held instruction into a bubble
    drive(WB_ALU, LD_W, 32'h0000_0066, 32'h0, 32'h0000_0520, 5'd13, 1'b1);
    @(posedge clk); #1;
    valid_in = 1'b0; write_reg_in = 1'b0;
    stall = 1'b1; nullify = 1'b1;
    @(negedge clk);
    check("nullstall_write_reg", {31'd0, write_reg}, 32'd0);
    @(posedge clk); #1;
    stall = 1'b0; nullify = 1'b0;
    @(negedge clk);
    check("nullify_retire_valid", {31'd0, retire_valid}, 32'd0);
    check("nullify_write_reg", {31'd0, write_reg}, 32'd0);
    check("nullify_count", retired_count, exp_count);

`ifdef STAGE_WRITEBACK_BYPASS_EN
    rs_addr = 5'd7; rs_rf = 32'h11; rt_addr = 5'd3; rt_rf = 32'h22;
    send(WB_ALU, LD_W, 32'h0000_00AA, 32'h0, 32'h0000_0540, 5'd7, 1'b1, 32'h0000_00AA);
    check("bypass_rs_fwd", rs_fwd, 32'h0000_00AA);
    check("bypass_rt_fwd", rt_fwd, 32'h0000_0022);
    rs_addr = 5'd0;
    send(WB_ALU, LD_W, 32'h0000_00BB, 32'h0, 32'h0000_0544, 5'd0, 1'b1, 32'h0000_00BB);
    check("bypass_rs_zero", rs_fwd, 32'h0000_0011);
`endif

    // Async reset mid-stall clears every output without waiting for an edge
    send(WB_ALU, LD_W, 32'h0000_0099, 32'h0, 32'h0000_0600, 5'd14, 1'b1, 32'h0000_0099);
    stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    exp_count = 32'd0;
    @(negedge clk); #1;
    reset = 1'b1;
    stall = 1'b0;
    send(WB_ALU, LD_W, 32'h0000_0123, 32'h0, 32'h0000_0700, 5'd15, 1'b1, 32'h0000_0123);
    @(posedge clk); #1;
    check("count_after_reset", retired_count, 32'd1);

    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
